btb_update_gen: RTL and testbench
=================================

BTB_UPDATE_GEN -- requirements
Module: btb_update_gen

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning update FIFO entries; power of two, >= 2.
REQ-002 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port flush_i  input  1  discard all pending updates.
REQ-005 SHALL have port debug_mode_i  input  1  high: suppress capture of new resolutions.
REQ-006 SHALL have port resolve_valid_i  input  1  resolved control-flow instruction present this cycle.
REQ-007 SHALL have port resolve_pc_i  input  riscv::VLEN  PC of resolved instruction.
REQ-008 SHALL have port resolve_target_i  input  riscv::VLEN  actual jump target.
REQ-009 SHALL have port resolve_mispredict_i  input  1  prediction was wrong.
REQ-010 SHALL have port resolve_is_jumpr_i  input  1  instruction is a register-indirect jump.
REQ-011 SHALL have port checkpoint_req_i  input  1  requested predictor bank (0 = A, 1 = B).
REQ-012 SHALL have port btb_update_o  output  ariane_pkg::btb_update_t  registered update (valid, pc, target_address) to the BTB bank mux.
REQ-013 SHALL have port checkpoint_mode_o  output  1  applied bank select driven to the BTB bank mux.
REQ-014 SHALL have port drop_cnt_o  output  8  saturating count of lost qualifying resolutions.

Function
REQ-015 Qualifying resolution SHALL be resolve_valid_i & resolve_mispredict_i & resolve_is_jumpr_i & !debug_mode_i.
REQ-016 In RUN, a qualifying resolution SHALL be written {pc, target} at FIFO tail on that cycle's edge.
REQ-017 In RUN or DRAIN, when FIFO non-empty, each edge SHALL pop the head into btb_update_o with valid=1; when empty, valid SHALL load 0.
REQ-018 Latency: resolution sampled at the edge ending cycle N into an empty FIFO SHALL appear as btb_update_o.valid=1 in cycle N+2; throughput one update per cycle.
REQ-019 btb_update_o.valid SHALL be high for exactly one cycle per entry; pc/target SHALL hold their last value when valid=0.
REQ-020 FIFO full with no pop: qualifying resolution SHALL be dropped and drop_cnt_o incremented.
REQ-021 FIFO full with pop in the same cycle: push SHALL be accepted, no drop.
REQ-022 drop_cnt_o SHALL saturate at 255, never wrap.
REQ-023 FSM states: RUN, DRAIN, SWITCH.
REQ-024 RUN -> DRAIN when checkpoint_req_i != checkpoint_mode_o.
REQ-025 In DRAIN, qualifying resolutions SHALL be dropped and counted; popping continues.
REQ-026 DRAIN -> SWITCH when FIFO empty and btb_update_o.valid=0.
REQ-027 SWITCH SHALL last one cycle with valid=0; on exit edge checkpoint_mode_o <= checkpoint_req_i, state -> RUN.
REQ-028 checkpoint_req_i reverting during DRAIN SHALL NOT abort the drain; SWITCH then loads the current request (possibly unchanged).
REQ-029 flush_i SHALL, on that edge, empty the FIFO, clear btb_update_o.valid, force RUN; checkpoint_mode_o and drop_cnt_o unchanged.
REQ-030 A resolution coincident with flush_i SHALL be discarded and not counted.
REQ-031 flush_i SHALL take priority over every other event.

Reset
REQ-032 rst_i high SHALL immediately force: FIFO empty, btb_update_o all-zero, checkpoint_mode_o=0, drop_cnt_o=0, state RUN.
REQ-033 Reset mid-drain SHALL abandon the drain with no pending update emitted.

Configuration
REQ-034 Macro BTB_UPD_DROP_CNT_EN defined: drop counter implemented per REQ-020..022.
REQ-035 Macro undefined: no counter register; drop_cnt_o tied to 0; drop behaviour otherwise identical.

Verification
REQ-036 Single qualifying resolution pc=0x1000, target=0x2000 in cycle 5 -> btb_update_o valid=1, pc=0x1000, target=0x2000 in cycle 7 only.
REQ-037 DEPTH=4, six back-to-back qualifying resolutions -> all six emitted in order, one per cycle, drop_cnt_o=0 (pop frees slot).
REQ-038 Mispredict with resolve_is_jumpr_i=0, or debug_mode_i=1 -> no update, drop_cnt_o unchanged.
REQ-039 Three entries queued, checkpoint_req_i 0->1 -> three updates at mode 0, one idle SWITCH cycle, then checkpoint_mode_o=1; resolution during DRAIN -> drop_cnt_o +1.
REQ-040 Three entries queued plus flush_i with a coincident resolution -> next cycle valid=0, no further updates, drop_cnt_o unchanged.
REQ-041 300 drops with FIFO held full -> drop_cnt_o=255; without BTB_UPD_DROP_CNT_EN -> drop_cnt_o=0.

Source files
------------

// File: rtl/btb_update_gen_if.sv
// Resolution/update bus of the BTB update generator, plus the minimal riscv and
// ariane_pkg definitions it depends on (VLEN and the BTB update record).
package riscv;
    localparam int unsigned VLEN = 64;
endpackage

package ariane_pkg;
    typedef struct packed {
        logic                   valid;
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target_address;
    } btb_update_t;
endpackage

// Handshake: resolve_valid_i is a one-cycle strobe with no back-pressure.
// btb_update_o.valid is high for exactly one cycle per emitted update.
interface btb_update_gen_if;
    logic                    resolve_valid_i;
    logic [riscv::VLEN-1:0]  resolve_pc_i;
    logic [riscv::VLEN-1:0]  resolve_target_i;
    logic                    resolve_mispredict_i;
    logic                    resolve_is_jumpr_i;
    ariane_pkg::btb_update_t btb_update_o;

    modport master (
        output resolve_valid_i, resolve_pc_i, resolve_target_i,
               resolve_mispredict_i, resolve_is_jumpr_i,
        input  btb_update_o
    );

    modport slave (
        input  resolve_valid_i, resolve_pc_i, resolve_target_i,
               resolve_mispredict_i, resolve_is_jumpr_i,
        output btb_update_o
    );
endinterface

// File: rtl/btb_update_gen.sv
// Queues mispredicted indirect-jump resolutions and replays them as BTB updates,
// draining before a predictor bank switch. Optional drop counter: BTB_UPD_DROP_CNT_EN.
module btb_update_gen #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    input  logic                   debug_mode_i,
    input  logic                   checkpoint_req_i,
    btb_update_gen_if.slave        bus,
    output logic                   checkpoint_mode_o,
    output logic [7:0]             drop_cnt_o,
    output logic [1:0]             state_o
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_e;

    typedef struct packed {
        logic [riscv::VLEN-1:0] pc;
        logic [riscv::VLEN-1:0] target;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] fill;
    logic          fifo_empty;
    logic          fifo_full;
    logic          qualify;
    logic          pop;
    logic          push;
    state_e        state;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    always_comb begin
        fill       = wr_ptr - rd_ptr;
        fifo_empty = (fill == '0);
        fifo_full  = (fill == PW'(DEPTH));
        qualify    = bus.resolve_valid_i & bus.resolve_mispredict_i &
                     bus.resolve_is_jumpr_i & ~debug_mode_i;
        pop        = ~flush_i & (state != SWITCH) & ~fifo_empty;
        // A pop on the same edge frees the slot the push needs.
        push       = ~flush_i & (state == RUN) & qualify & (~fifo_full | pop);
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= '{pc: bus.resolve_pc_i, target: bus.resolve_target_i};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            bus.btb_update_o  <= '0;
            checkpoint_mode_o <= 1'b0;
            state             <= RUN;
        end else if (flush_i) begin
            rd_ptr                 <= wr_ptr;
            bus.btb_update_o.valid <= 1'b0;
            state                  <= RUN;
        end else begin
            if (pop) begin
                rd_ptr                          <= rd_ptr + 1'b1;
                bus.btb_update_o.valid          <= 1'b1;
                bus.btb_update_o.pc             <= mem[rd_ptr[AW-1:0]].pc;
                bus.btb_update_o.target_address <= mem[rd_ptr[AW-1:0]].target;
            end else begin
                bus.btb_update_o.valid <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                RUN: begin
                    if (checkpoint_req_i != checkpoint_mode_o) state <= DRAIN;
                end
                DRAIN: begin
                    // Wait until the last popped update has also left the output register.
                    if (fifo_empty && !bus.btb_update_o.valid) state <= SWITCH;
                end
                SWITCH: begin
                    checkpoint_mode_o <= checkpoint_req_i;
                    state             <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    assign state_o = state;

`ifdef BTB_UPD_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q;

    assign drop = qualify & ~push & ~flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end

    assign drop_cnt_o = drop_cnt_q;
`else
    assign drop_cnt_o = '0;
`endif

endmodule

// File: tb/tb_btb_update_gen.sv
// Directed plus randomized bench for btb_update_gen against a queue-based reference model.
module tb_btb_update_gen;
    localparam int DEPTH = 4;
    localparam int P_RUN = 0, P_DRAIN = 1, P_SWITCH = 2;
`ifdef BTB_UPD_DROP_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       dbg = 1'b0;
    logic       req = 1'b0;
    logic       mode;
    logic [7:0] drop_cnt;
    logic [1:0] state_dbg;

    btb_update_gen_if upd_if ();

    btb_update_gen #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush),
        .debug_mode_i      (dbg),
        .checkpoint_req_i  (req),
        .bus               (upd_if),
        .checkpoint_mode_o (mode),
        .drop_cnt_o        (drop_cnt),
        .state_o           (state_dbg)
    );

    always #5 clk = ~clk;

    // Reference model: pending updates in order, plus expected output registers.
    logic [127:0] exp_q[$];
    int           m_phase;
    bit           m_mode;
    bit           m_valid;
    logic [63:0]  m_pc;
    logic [63:0]  m_tg;
    int           m_drops;
    int           n_checks = 0;
    int           n_fail = 0;
    string        phase_tag = "reset";

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s/%s observed=%h expected=%h", phase_tag, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_phase = P_RUN;
        m_mode  = 1'b0;
        m_valid = 1'b0;
        m_pc    = '0;
        m_tg    = '0;
        m_drops = 0;
    endtask

    function automatic logic [63:0] exp_drop();
        if (!CNT_EN) return 64'd0;
        return (m_drops > 255) ? 64'd255 : 64'(m_drops);
    endfunction

    task automatic check_outputs();
        check("valid",  64'(upd_if.btb_update_o.valid), 64'(m_valid));
        check("pc",     upd_if.btb_update_o.pc, m_pc);
        check("target", upd_if.btb_update_o.target_address, m_tg);
        check("mode",   64'(mode), 64'(m_mode));
        check("drops",  64'(drop_cnt), exp_drop());
    endtask

    task automatic model_step(input bit v, input bit mis, input bit jr, input bit d,
                              input bit rq, input bit fl,
                              input logic [63:0] pc, input logic [63:0] tg);
        bit qual;
        int occ;
        bit popping;
        bit accept;
        qual = v && mis && jr && !d;
        if (fl) begin
            exp_q.delete();
            m_valid = 1'b0;
            m_phase = P_RUN;
            return;
        end
        occ     = exp_q.size();
        popping = (m_phase != P_SWITCH) && (occ > 0);
        accept  = (m_phase == P_RUN) && qual && ((occ < DEPTH) || popping);
        if (qual && !accept) m_drops++;
        if (m_phase == P_RUN) begin
            if (rq != m_mode) m_phase = P_DRAIN;
        end else if (m_phase == P_DRAIN) begin
            if (occ == 0 && !m_valid) m_phase = P_SWITCH;
        end else begin
            m_mode  = rq;
            m_phase = P_RUN;
        end
        if (popping) begin
            {m_pc, m_tg} = exp_q.pop_front();
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (accept) exp_q.push_back({pc, tg});
    endtask

    // One clock cycle: check current outputs, drive new inputs, advance the model.
    task automatic cycle(input bit v, input bit mis, input bit jr, input bit d,
                         input bit rq, input bit fl,
                         input logic [63:0] pc, input logic [63:0] tg);
        @(negedge clk);
        check_outputs();
        upd_if.resolve_valid_i      = v;
        upd_if.resolve_mispredict_i = mis;
        upd_if.resolve_is_jumpr_i   = jr;
        upd_if.resolve_pc_i         = pc;
        upd_if.resolve_target_i     = tg;
        dbg   = d;
        req   = rq;
        flush = fl;
        model_step(v, mis, jr, d, rq, fl, pc, tg);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, req, 0, 64'h0, 64'h0);
    endtask

    task automatic check_reset_values();
        check("rst_valid",  64'(upd_if.btb_update_o.valid), 64'd0);
        check("rst_pc",     upd_if.btb_update_o.pc, 64'd0);
        check("rst_target", upd_if.btb_update_o.target_address, 64'd0);
        check("rst_mode",   64'(mode), 64'd0);
        check("rst_drops",  64'(drop_cnt), 64'd0);
    endtask

    initial begin
        upd_if.resolve_valid_i      = 1'b0;
        upd_if.resolve_mispredict_i = 1'b0;
        upd_if.resolve_is_jumpr_i   = 1'b0;
        upd_if.resolve_pc_i         = '0;
        upd_if.resolve_target_i     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset_values();
        rst = 1'b0;

        // Single resolution in cycle 5, visible in cycle 7 only.
        phase_tag = "single";
        idle(5);
        cycle(1, 1, 1, 0, 0, 0, 64'h1000, 64'h2000);
        idle(4);

        phase_tag = "burst6";
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0, 0, 0, 64'h100 + 64'(i), 64'h900 + 64'(i));
        idle(3);

        phase_tag = "nonqual";
        cycle(1, 1, 0, 0, 0, 0, 64'h3000, 64'h4000);
        cycle(1, 1, 1, 1, 0, 0, 64'h3004, 64'h4004);
        cycle(1, 0, 1, 0, 0, 0, 64'h3008, 64'h4008);
        idle(3);

        phase_tag = "switch";
        cycle(1, 1, 1, 0, 0, 0, 64'h5000, 64'h6000);
        cycle(1, 1, 1, 0, 1, 0, 64'h5004, 64'h6004);
        cycle(1, 1, 1, 0, 1, 0, 64'h5008, 64'h6008);
        cycle(0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        idle(5);

        phase_tag = "flush";
        cycle(1, 1, 1, 0, req, 0, 64'h7000, 64'h8000);
        cycle(1, 1, 1, 0, req, 0, 64'h7004, 64'h8004);
        cycle(1, 1, 1, 0, req, 1, 64'h7008, 64'h8008);
        idle(4);

        phase_tag = "random";
        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                  ($urandom_range(0, 19) == 0) ? ~req : req,
                  $urandom_range(0, 29) == 0,
                  {$urandom, $urandom}, {$urandom, $urandom});
        end
        idle(6);

        // Keep requesting the other bank so resolutions keep landing in DRAIN/SWITCH.
        phase_tag = "saturate";
        for (int i = 0; i < 450; i++) begin
            cycle(1, 1, 1, 0, ~m_mode, 0, {$urandom, $urandom}, {$urandom, $urandom});
        end
        idle(6);
        check("drops_final", 64'(drop_cnt), CNT_EN ? 64'd255 : 64'd0);

        phase_tag = "reset_drain";
        cycle(1, 1, 1, 0, req, 0, 64'hA000, 64'hB000);
        cycle(1, 1, 1, 0, ~req, 0, 64'hA004, 64'hB004);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_values();
        upd_if.resolve_valid_i = 1'b0;
        req = 1'b0;
        model_reset();
        @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        idle(6);
        @(negedge clk);
        check_outputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
